// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared types, status codes and sizing helper for the command dispatcher
package dispatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_NAK,
    S_DRAIN
  } state_t;

  localparam logic [7:0] ST_IDLE = 8'h00;
  localparam logic [7:0] ST_NAK  = 8'hE0;
  localparam logic [7:0] ST_TMO  = 8'hE1;

  // A single client still needs a 1-bit index so port widths never collapse to zero.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dispatch_opcode_lut.sv
// rtl/dispatch_opcode_lut.sv - combinational opcode lookup, lowest matching client index wins
module dispatch_opcode_lut
  import dispatch_pkg::*;
#(
  parameter int unsigned              N_CLIENTS = 5,
  parameter logic [N_CLIENTS*8-1:0]   OPCODES   = {8'h23, 8'h22, 8'h21, 8'h72, 8'h71},
  parameter int                       IDX_W     = idx_width(N_CLIENTS)
) (
  input  logic [7:0]       rx_data,
  output logic             hit,
  output logic [IDX_W-1:0] index
);

  // Scanning from the top down lets the lowest duplicate overwrite the others.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (OPCODES[8*i +: 8] == rx_data) begin
        hit   = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/cmd_dispatcher.sv
// rtl/cmd_dispatcher.sv - UART opcode dispatcher granting one client at a time to TX and sample RAM
module cmd_dispatcher
  import dispatch_pkg::*;
#(
  parameter int unsigned             N_CLIENTS   = 5,
  parameter logic [N_CLIENTS*8-1:0]  OPCODES     = {8'h23, 8'h22, 8'h21, 8'h72, 8'h71},
  parameter int unsigned             ADDR_W      = 8,
  parameter int unsigned             DATA_W      = 8,
  parameter logic [31:0]             TIMEOUT_CYC = 32'd50_000_000,
  parameter logic [7:0]              NAK_BYTE    = 8'hEE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_ready,
  input  logic [7:0]                    rx_data,
  input  logic                          tx_active,
  output logic [7:0]                    tx_data,
  output logic                          tx_start,
  output logic [N_CLIENTS-1:0]          activate,
  input  logic [N_CLIENTS-1:0]          done,
  input  logic [N_CLIENTS*8-1:0]        cl_tx_data,
  input  logic [N_CLIENTS-1:0]          cl_tx_start,
  input  logic [N_CLIENTS-1:0]          cl_mem_we,
  input  logic [N_CLIENTS-1:0]          cl_mem_oe,
  input  logic [N_CLIENTS*ADDR_W-1:0]   cl_mem_waddr,
  input  logic [N_CLIENTS*DATA_W-1:0]   cl_mem_wdata,
  input  logic [N_CLIENTS*ADDR_W-1:0]   cl_mem_raddr,
  output logic                          mem_we,
  output logic                          mem_oe,
  output logic [ADDR_W-1:0]             mem_waddr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [ADDR_W-1:0]             mem_raddr,
  output logic [7:0]                    status,
  output logic                          err
);

  localparam int IDX_W = idx_width(N_CLIENTS);

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [7:0]         status_n;
  logic               err_n;
  logic [31:0]        wdog, wdog_n;
  logic               lut_hit;
  logic [IDX_W-1:0]   lut_idx;
  logic               sel_done;

  dispatch_opcode_lut #(
    .N_CLIENTS (N_CLIENTS),
    .OPCODES   (OPCODES),
    .IDX_W     (IDX_W)
  ) u_lut (
    .rx_data (rx_data),
    .hit     (lut_hit),
    .index   (lut_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      idx    <= '0;
      status <= ST_IDLE;
      err    <= 1'b0;
      wdog   <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      status <= status_n;
      err    <= err_n;
      wdog   <= wdog_n;
    end
  end

  // Grant decode straight from registered state keeps activate one-hot by construction.
  always_comb begin
    activate = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      activate[i] = (state == S_GRANT) && (idx == IDX_W'(i));
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    status_n  = status;
    err_n     = err;
    wdog_n    = wdog;
    sel_done  = 1'b0;
    tx_data   = '0;
    tx_start  = 1'b0;
    mem_we    = 1'b0;
    mem_oe    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_raddr = '0;

    case (state)
      S_IDLE: begin
        if (rx_ready) begin
          if (lut_hit) begin
            state_n  = S_GRANT;
            idx_n    = lut_idx;
            status_n = rx_data;
            err_n    = 1'b0;
            wdog_n   = '0;
          end else begin
            state_n  = S_NAK;
            status_n = ST_NAK;
            err_n    = 1'b1;
          end
        end
      end

      S_GRANT: begin
        for (int i = 0; i < N_CLIENTS; i++) begin
          if (idx == IDX_W'(i)) begin
            tx_data   = cl_tx_data[8*i +: 8];
            tx_start  = cl_tx_start[i];
            mem_we    = cl_mem_we[i];
            mem_oe    = cl_mem_oe[i];
            mem_waddr = cl_mem_waddr[ADDR_W*i +: ADDR_W];
            mem_wdata = cl_mem_wdata[DATA_W*i +: DATA_W];
            mem_raddr = cl_mem_raddr[ADDR_W*i +: ADDR_W];
            sel_done  = done[i];
          end
        end
        wdog_n = wdog + 32'd1;
        // Completion takes priority over a watchdog expiry landing on the same cycle.
        if (sel_done) begin
          state_n  = S_DRAIN;
          status_n = ST_IDLE;
        end else if ((TIMEOUT_CYC != 32'd0) && (wdog == TIMEOUT_CYC - 32'd1)) begin
          state_n  = S_NAK;
          status_n = ST_TMO;
          err_n    = 1'b1;
        end
      end

      S_NAK: begin
        tx_data = NAK_BYTE;
        if (!tx_active) begin
          tx_start = 1'b1;
          state_n  = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (!rx_ready && !tx_active) begin
          state_n = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  assert property (@(posedge clk) disable iff (reset) $onehot0(activate));

endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb/tb_cmd_dispatcher.sv - randomized self-checking bench for cmd_dispatcher
module tb_cmd_dispatcher;

  localparam int N   = 5;
  localparam int TMO = 100;

  logic             clk = 1'b0;
  logic             reset, rx_ready, tx_active, tx_start, mem_we, mem_oe, err;
  logic [7:0]       rx_data, tx_data, status, mem_waddr, mem_wdata, mem_raddr;
  logic [N-1:0]     activate, done, cl_tx_start, cl_mem_we, cl_mem_oe;
  logic [N*8-1:0]   cl_tx_data, cl_mem_waddr, cl_mem_wdata, cl_mem_raddr;
  logic [34:0]      mux_obs;

  int checks = 0;
  int errors = 0;

  logic [7:0] opc_tab [N] = '{8'h71, 8'h72, 8'h21, 8'h22, 8'h23};

  assign mux_obs = {tx_start, mem_we, mem_oe, tx_data, mem_waddr, mem_wdata, mem_raddr};

  cmd_dispatcher #(
    .N_CLIENTS   (N),
    .OPCODES     ({8'h23, 8'h22, 8'h21, 8'h72, 8'h71}),
    .ADDR_W      (8),
    .DATA_W      (8),
    .TIMEOUT_CYC (32'd100),
    .NAK_BYTE    (8'hEE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .tx_active    (tx_active),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .activate     (activate),
    .done         (done),
    .cl_tx_data   (cl_tx_data),
    .cl_tx_start  (cl_tx_start),
    .cl_mem_we    (cl_mem_we),
    .cl_mem_oe    (cl_mem_oe),
    .cl_mem_waddr (cl_mem_waddr),
    .cl_mem_wdata (cl_mem_wdata),
    .cl_mem_raddr (cl_mem_raddr),
    .mem_we       (mem_we),
    .mem_oe       (mem_oe),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_raddr    (mem_raddr),
    .status       (status),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish within 50000 cycles");
    $fatal(1, "bench timeout");
  end

  function automatic int ref_find(input logic [7:0] b);
    for (int i = 0; i < N; i++) if (opc_tab[i] == b) return i;
    return -1;
  endfunction

  function automatic logic [34:0] exp_mux(input int k);
    return {cl_tx_start[k], cl_mem_we[k], cl_mem_oe[k], cl_tx_data[8*k +: 8],
            cl_mem_waddr[8*k +: 8], cl_mem_wdata[8*k +: 8], cl_mem_raddr[8*k +: 8]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_clients();
    for (int i = 0; i < N; i++) begin
      cl_tx_data[8*i +: 8]   = 8'($urandom);
      cl_mem_waddr[8*i +: 8] = 8'($urandom);
      cl_mem_wdata[8*i +: 8] = 8'($urandom);
      cl_mem_raddr[8*i +: 8] = 8'($urandom);
    end
    cl_tx_start = N'($urandom);
    cl_mem_we   = N'($urandom);
    cl_mem_oe   = N'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_ready = 1'b1;
    rx_data  = b;
    tick();
    rx_ready = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rand_clients();
    tick();
    tick();
    checks++;
    if ({activate, status, err} !== {N'(0), 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_regs: got act=%b status=%h err=%b want 0/00/0", activate, status, err);
    end
    checks++;
    if (mux_obs !== 35'd0) begin
      errors++;
      $display("FAIL reset_mux: got %h want 0", mux_obs);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_grant();
    for (int t = 0; t < 12; t++) begin
      int k = $urandom_range(0, N - 1);
      int d = $urandom_range(1, 25);
      logic [N-1:0] exp_act;
      exp_act    = '0;
      exp_act[k] = 1'b1;
      send_byte(opc_tab[k]);
      for (int c = 0; c < d; c++) begin
        rand_clients();
        done    = N'($urandom);
        done[k] = (c == d - 1);
        #1;
        checks++;
        if ({activate, status, err} !== {exp_act, opc_tab[k], 1'b0}) begin
          errors++;
          $display("FAIL grant_state c=%0d: got act=%b status=%h err=%b want %b/%h/0",
                   c, activate, status, err, exp_act, opc_tab[k]);
        end
        checks++;
        if (mux_obs !== exp_mux(k)) begin
          errors++;
          $display("FAIL grant_mux k=%0d: got %h want %h", k, mux_obs, exp_mux(k));
        end
        tick();
      end
      done = '0;
      rand_clients();
      #1;
      checks++;
      if ({activate, status, mux_obs} !== {N'(0), 8'h00, 35'd0}) begin
        errors++;
        $display("FAIL grant_release: got act=%b status=%h mux=%h want 0/00/0", activate, status, mux_obs);
      end
      tick();
    end
  endtask

  task automatic test_nak();
    int w = $urandom_range(1, 10);
    logic [7:0] b;
    do b = 8'($urandom); while (ref_find(b) >= 0);
    tx_active = 1'b1;
    send_byte(b);
    for (int c = 0; c < w; c++) begin
      rand_clients();
      #1;
      checks++;
      if ({activate, status, err, tx_start, mem_we, mem_oe} !== {N'(0), 8'hE0, 1'b1, 3'b000}) begin
        errors++;
        $display("FAIL nak_wait: got act=%b status=%h err=%b start=%b we=%b oe=%b want 0/E0/1/0/0/0",
                 activate, status, err, tx_start, mem_we, mem_oe);
      end
      tick();
    end
    tx_active = 1'b0;
    #1;
    checks++;
    if ({tx_start, tx_data} !== {1'b1, 8'hEE}) begin
      errors++;
      $display("FAIL nak_send: got start=%b data=%h want 1/EE", tx_start, tx_data);
    end
    tick();
    checks++;
    if (tx_start !== 1'b0) begin
      errors++;
      $display("FAIL nak_single: got start=%b want 0", tx_start);
    end
    rx_ready = 1'b1;
    rx_data  = 8'h71;
    tick();
    rx_ready = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({activate, tx_start, status, err} !== {N'(0), 1'b0, 8'hE0, 1'b1}) begin
        errors++;
        $display("FAIL drain_drop: got act=%b start=%b status=%h err=%b want 0/0/E0/1",
                 activate, tx_start, status, err);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    tx_active = 1'b0;
    send_byte(8'h21);
    while (activate === 5'b00100 && cnt < 300) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt !== TMO) begin
      errors++;
      $display("FAIL tmo_len: got %0d grant cycles want %0d", cnt, TMO);
    end
    checks++;
    if ({activate, tx_start, tx_data, status, err} !== {N'(0), 1'b1, 8'hEE, 8'hE1, 1'b1}) begin
      errors++;
      $display("FAIL tmo_nak: got act=%b start=%b data=%h status=%h err=%b want 0/1/EE/E1/1",
               activate, tx_start, tx_data, status, err);
    end
    tick();
    tick();
    send_byte(8'h21);
    checks++;
    if ({activate, status, err} !== {5'b00100, 8'h21, 1'b0}) begin
      errors++;
      $display("FAIL tmo_retry: got act=%b status=%h err=%b want 00100/21/0", activate, status, err);
    end
    done[2] = 1'b1;
    tick();
    done = '0;
    tick();
  endtask

  task automatic test_done_expiry();
    send_byte(8'h23);
    for (int c = 1; c < TMO; c++) tick();
    checks++;
    if (activate !== 5'b10000) begin
      errors++;
      $display("FAIL expiry_last: got act=%b want 10000", activate);
    end
    done[4] = 1'b1;
    tick();
    done = '0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({activate, tx_start, status, err} !== {N'(0), 1'b0, 8'h00, 1'b0}) begin
        errors++;
        $display("FAIL expiry_done_wins: got act=%b start=%b status=%h err=%b want 0/0/00/0",
                 activate, tx_start, status, err);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    send_byte(8'h72);
    tx_active = 1'b1;
    rand_clients();
    cl_mem_we = '1;
    cl_mem_oe = '1;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({activate, status, err, mux_obs} !== {N'(0), 8'h00, 1'b0, 35'd0}) begin
      errors++;
      $display("FAIL reset_mid: got act=%b status=%h err=%b mux=%h want all 0", activate, status, err, mux_obs);
    end
    reset     = 1'b0;
    tx_active = 1'b0;
    tick();
    send_byte(8'h71);
    checks++;
    if ({activate, status} !== {5'b00001, 8'h71}) begin
      errors++;
      $display("FAIL reset_regrant: got act=%b status=%h want 00001/71", activate, status);
    end
    done[0] = 1'b1;
    tick();
    done = '0;
    tick();
    do b = 8'($urandom); while (ref_find(b) >= 0);
    tx_active = 1'b1;
    send_byte(b);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    tx_active = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({tx_start, err, status} !== {1'b0, 1'b0, 8'h00}) begin
        errors++;
        $display("FAIL reset_nak_cancel: got start=%b err=%b status=%h want 0/0/00", tx_start, err, status);
      end
      tick();
    end
  endtask

  initial begin
    reset     = 1'b1;
    rx_ready  = 1'b0;
    rx_data   = 8'h00;
    tx_active = 1'b0;
    done      = '0;
    rand_clients();
    test_reset();
    test_grant();
    test_nak();
    test_timeout();
    test_done_expiry();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
